// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end that serialises operand loads into a shared ALU and returns its result.
// Latency: grant in N, loads N+1..N+3, response N+5; inputs are ignored while busy, so no backpressure is exerted.
module alu_arbiter_seq #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [NB_DATA-1:0] i_a0,
  input  logic [NB_DATA-1:0] i_b0,
  input  logic [NB_DATA-1:0] i_a1,
  input  logic [NB_DATA-1:0] i_b1,
  input  logic [NB_OP-1:0]   i_op0,
  input  logic [NB_OP-1:0]   i_op1,
  output logic [1:0]         o_gnt,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_A,
  output logic               o_en_B,
  output logic               o_en_OP,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_overflow,
  output logic [1:0]         o_rsp_valid,
  output logic [NB_DATA-1:0] o_rsp_result,
  output logic               o_rsp_zero,
  output logic               o_rsp_overflow,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    WAIT    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t             state;
  logic               ptr;
  logic               win_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic               win;
  logic               grant;

  // Contention goes to the pointer holder; a lone request wins outright.
  always_comb begin
    win = (i_req == 2'b11) ? ptr : i_req[1];
  end

  // Gated by reset so a request held through reset cannot show a grant.
  assign grant = i_rst && (state == IDLE) && (i_req != 2'b00);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state          <= IDLE;
      ptr            <= 1'b0;
      win_q          <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      o_rsp_result   <= '0;
      o_rsp_zero     <= 1'b0;
      o_rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            win_q <= win;
            a_q   <= win ? i_a1  : i_a0;
            b_q   <= win ? i_b1  : i_b0;
            op_q  <= win ? i_op1 : i_op0;
            state <= LOAD_A;
          end
        end
        LOAD_A:  state <= LOAD_B;
        LOAD_B:  state <= LOAD_OP;
        LOAD_OP: state <= WAIT;
        WAIT: begin
          // ALU registers took the opcode at the end of LOAD_OP, so its outputs are settled here.
          o_rsp_result   <= i_alu_result;
          o_rsp_zero     <= i_alu_zero;
          o_rsp_overflow <= i_alu_overflow;
          state          <= RESP;
        end
        RESP: begin
          ptr   <= ~win_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_gnt       = 2'b00;
    o_rsp_valid = 2'b00;
    o_en_A      = 1'b0;
    o_en_B      = 1'b0;
    o_en_OP     = 1'b0;
    o_data      = '0;
    if (grant) begin
      o_gnt = win ? 2'b10 : 2'b01;
    end
    case (state)
      LOAD_A: begin
        o_en_A = 1'b1;
        o_data = a_q;
      end
      LOAD_B: begin
        o_en_B = 1'b1;
        o_data = b_q;
      end
      LOAD_OP: begin
        o_en_OP = 1'b1;
        o_data  = NB_DATA'(op_q);
      end
      RESP: o_rsp_valid = win_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a small registered ALU model on the load bus.
module tb_alu_arbiter_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_req;
  logic [7:0] i_a0, i_b0, i_a1, i_b1;
  logic [5:0] i_op0, i_op1;
  logic [1:0] o_gnt;
  logic [7:0] o_data;
  logic       o_en_A, o_en_B, o_en_OP;
  logic [7:0] i_alu_result;
  logic       i_alu_zero, i_alu_overflow;
  logic [1:0] o_rsp_valid;
  logic [7:0] o_rsp_result;
  logic       o_rsp_zero, o_rsp_overflow;
  logic       o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  alu_arbiter_seq #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_a0(i_a0), .i_b0(i_b0), .i_a1(i_a1), .i_b1(i_b1),
    .i_op0(i_op0), .i_op1(i_op1),
    .o_gnt(o_gnt), .o_data(o_data),
    .o_en_A(o_en_A), .o_en_B(o_en_B), .o_en_OP(o_en_OP),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_overflow(i_alu_overflow),
    .o_rsp_valid(o_rsp_valid), .o_rsp_result(o_rsp_result),
    .o_rsp_zero(o_rsp_zero), .o_rsp_overflow(o_rsp_overflow),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // ALU model: operand registers loaded from the shared bus, combinational result.
  logic [7:0] alu_a = '0, alu_b = '0;
  logic [5:0] alu_op = '0;
  always @(posedge i_clk) begin
    if (o_en_A)  alu_a  <= o_data;
    if (o_en_B)  alu_b  <= o_data;
    if (o_en_OP) alu_op <= o_data[5:0];
  end
  always_comb begin
    i_alu_result   = 8'd0;
    i_alu_overflow = 1'b0;
    case (alu_op)
      6'h20: begin
        i_alu_result   = alu_a + alu_b;
        i_alu_overflow = (alu_a[7] == alu_b[7]) && (i_alu_result[7] != alu_a[7]);
      end
      6'h22: begin
        i_alu_result   = alu_a - alu_b;
        i_alu_overflow = (alu_a[7] != alu_b[7]) && (i_alu_result[7] != alu_a[7]);
      end
      6'h24: i_alu_result = alu_a & alu_b;
      6'h25: i_alu_result = alu_a | alu_b;
      default: ;
    endcase
    i_alu_zero = (i_alu_result == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge of the grant cycle with inputs already applied.
  // Operand inputs are scrambled after the grant to show they no longer matter.
  task automatic txn(input logic w, input logic [7:0] ea, input logic [7:0] eb,
                     input logic [5:0] eop, input logic [7:0] eres, input logic ez,
                     input logic eo, input logic drop, input logic ghost);
    logic [1:0] oh;
    oh = w ? 2'b10 : 2'b01;
    check("gnt", o_gnt, oh);
    check("busy_grant", o_busy, 1'b0);
    @(negedge i_clk);
    i_a0 = 8'd99; i_b0 = 8'd98; i_a1 = 8'd97; i_b1 = 8'd96;
    i_op0 = 6'h24; i_op1 = 6'h25;
    if (drop) i_req = 2'b00;
    #1;
    check("gnt_off", o_gnt, 2'b00);
    check("en_A", {o_en_A, o_en_B, o_en_OP}, 3'b100);
    check("data_a", o_data, ea);
    check("busy", o_busy, 1'b1);
    @(negedge i_clk);
    if (ghost) i_req[1] = 1'b1;
    #1;
    check("en_B", {o_en_A, o_en_B, o_en_OP}, 3'b010);
    check("data_b", o_data, eb);
    check("gnt_busy", o_gnt, 2'b00);
    @(negedge i_clk); #1;
    check("en_OP", {o_en_A, o_en_B, o_en_OP}, 3'b001);
    check("data_op", o_data, {2'b00, eop});
    @(negedge i_clk);
    if (ghost) i_req = 2'b00;
    #1;
    check("en_wait", {o_en_A, o_en_B, o_en_OP}, 3'b000);
    check("data_wait", o_data, 8'd0);
    check("rsp_early", o_rsp_valid, 2'b00);
    @(negedge i_clk); #1;
    check("rsp_valid", o_rsp_valid, oh);
    check("rsp_result", o_rsp_result, eres);
    check("rsp_zero", o_rsp_zero, ez);
    check("rsp_ovf", o_rsp_overflow, eo);
    check("busy_resp", o_busy, 1'b1);
    @(negedge i_clk); #1;
    check("rsp_off", o_rsp_valid, 2'b00);
    check("busy_idle", o_busy, 1'b0);
    check("rsp_hold", o_rsp_result, eres);
  endtask

  initial begin
    i_rst = 1'b0; i_req = 2'b11;
    i_a0 = 8'd123; i_b0 = 8'd45;  i_op0 = 6'h20;
    i_a1 = 8'd50;  i_b1 = 8'd100; i_op1 = 6'h22;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_gnt", o_gnt, 2'b00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rsp", o_rsp_valid, 2'b00);
    check("rst_en", {o_en_A, o_en_B, o_en_OP}, 3'b000);
    check("rst_data", o_data, 8'd0);
    check("rst_result", {o_rsp_result, o_rsp_zero, o_rsp_overflow}, 10'd0);

    // Both requesting in the first cycle out of reset: 0 wins, then 1 back-to-back.
    i_rst = 1'b1;
    #1;
    txn(1'b0, 8'd123, 8'd45, 6'h20, 8'd168, 1'b0, 1'b1, 1'b0, 1'b0);
    i_a1 = 8'd50; i_b1 = 8'd100; i_op1 = 6'h22;
    i_a0 = 8'd100; i_b0 = 8'd100; i_op0 = 6'h20;
    #1;
    txn(1'b1, 8'd50, 8'd100, 6'h22, 8'hCE, 1'b0, 1'b0, 1'b0, 1'b0);
    i_a0 = 8'd100; i_b0 = 8'd100; i_op0 = 6'h20;
    i_a1 = 8'd0; i_b1 = 8'd0; i_op1 = 6'h20;
    #1;
    txn(1'b0, 8'd100, 8'd100, 6'h20, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0);
    i_a1 = 8'd0; i_b1 = 8'd0; i_op1 = 6'h20;
    #1;
    txn(1'b1, 8'd0, 8'd0, 6'h20, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("idle_gnt", o_gnt, 2'b00);

    // Operand change after grant, plus a request from 1 that vanishes while busy.
    i_req = 2'b01; i_a0 = 8'd10; i_b0 = 8'd3; i_op0 = 6'h20;
    #1;
    txn(1'b0, 8'd10, 8'd3, 6'h20, 8'd13, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ghost_gnt", o_gnt, 2'b00);
    @(negedge i_clk); #1;
    check("ghost_busy", o_busy, 1'b0);

    // Pointer now favours requester 1.
    i_req = 2'b11; i_a1 = 8'd200; i_b1 = 8'd55; i_op1 = 6'h22;
    i_a0 = 8'd1; i_b0 = 8'd1; i_op0 = 6'h20;
    #1;
    txn(1'b1, 8'd200, 8'd55, 6'h22, 8'd145, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset asserted during LOAD_B aborts the transaction.
    i_req = 2'b10; i_a1 = 8'd1; i_b1 = 8'd2; i_op1 = 6'h20;
    #1;
    check("abort_gnt", o_gnt, 2'b10);
    @(negedge i_clk);
    i_req = 2'b00;
    @(negedge i_clk); #1;
    check("abort_in_B", o_en_B, 1'b1);
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_en", {o_en_A, o_en_B, o_en_OP}, 3'b000);
    check("abort_data", o_data, 8'd0);
    check("abort_result", o_rsp_result, 8'd0);
    i_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); #1;
      check("abort_no_rsp", o_rsp_valid, 2'b00);
    end

    i_req = 2'b10; i_a1 = 8'hF0; i_b1 = 8'h0F; i_op1 = 6'h25;
    #1;
    txn(1'b1, 8'hF0, 8'h0F, 6'h25, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_seq.md
ALU_ARBITER_SEQ -- requirements
Module: alu_arbiter_seq

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, ALU operand/result width.
REQ-002 SHALL have parameter NB_OP, default 6, ALU opcode width; NB_OP <= NB_DATA.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_req  input  2  per-requester level request; bit k = requester k.
REQ-006 SHALL have ports i_a0, i_b0, i_a1, i_b1  input  NB_DATA  operands of requester 0/1.
REQ-007 SHALL have ports i_op0, i_op1  input  NB_OP  opcode of requester 0/1.
REQ-008 SHALL have port o_gnt  output  2  one-hot, one-cycle grant pulse.
REQ-009 SHALL have port o_data  output  NB_DATA  shared ALU load bus.
REQ-010 SHALL have ports o_en_A, o_en_B, o_en_OP  output  1  ALU register load enables.
REQ-011 SHALL have ports i_alu_result (NB_DATA), i_alu_zero (1), i_alu_overflow (1)  input  ALU outputs.
REQ-012 SHALL have port o_rsp_valid  output  2  one-hot, one-cycle response pulse to requester k.
REQ-013 SHALL have ports o_rsp_result (NB_DATA), o_rsp_zero (1), o_rsp_overflow (1)  output  captured response.
REQ-014 SHALL have port o_busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD_A -> LOAD_B -> LOAD_OP -> WAIT -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-016 In IDLE with any i_req bit set, SHALL pick winner, capture its a/b/op into internal registers, pulse o_gnt[winner], and go to LOAD_A.
REQ-017 Arbitration SHALL be round-robin over a 1-bit priority pointer: single request wins outright; on simultaneous requests, the pointer holder wins.
REQ-018 Pointer SHALL move to the non-winner on RESP exit; pointer SHALL reset to 0.
REQ-019 SHALL assert in LOAD_A: o_en_A=1, o_data=captured a; LOAD_B: o_en_B=1, o_data=captured b; LOAD_OP: o_en_OP=1, o_data={zeros, captured op}.
REQ-020 Outside LOAD_A/LOAD_B/LOAD_OP, SHALL drive all enables 0 and o_data 0; at most one enable high in any cycle.
REQ-021 SHALL register i_alu_result/zero/overflow on the WAIT->RESP edge into o_rsp_*; o_rsp_* SHALL hold until the next capture.
REQ-022 SHALL assert o_rsp_valid[winner] for exactly the RESP cycle.
REQ-023 Latency: grant in cycle N; enables in N+1..N+3; o_rsp_valid in N+5; next grant no earlier than N+6.
REQ-024 i_req and operand inputs SHALL be ignored while o_busy=1; changes after grant SHALL not affect the transaction.
REQ-025 A request deasserted before grant SHALL produce no grant and no pointer change.
REQ-026 o_gnt SHALL be 0 outside the granting IDLE cycle; o_gnt and o_rsp_valid SHALL never have more than one bit set.

Reset
REQ-027 With i_rst=0 at a rising edge, state SHALL become IDLE, pointer 0, captured operands 0, o_rsp_result/zero/overflow 0.
REQ-028 During and after reset, SHALL drive o_gnt, o_rsp_valid, enables, o_data, o_busy all 0.
REQ-029 Reset mid-transaction SHALL abort it with no o_rsp_valid pulse for the aborted transaction.
REQ-030 In the first cycle with i_rst=1, a request SHALL be arbitrated normally.

Verification
REQ-031 Scenario: i_req=01, a0=123, b0=45, op0=100000, ALU model. Response: o_gnt=01 at N; o_data 123/45/0x20 with en_A/en_B/en_OP at N+1/N+2/N+3; o_rsp_valid=01 at N+5, result 168, zero 0.
REQ-032 Scenario: i_req=11 in the first cycle after reset. Response: requester 0 granted at N, o_rsp_valid=01 at N+5, o_gnt=10 at N+6, o_rsp_valid=10 at N+11.
REQ-033 Scenario: i_req=11 held for four transactions. Response: grant order 0,1,0,1; no starvation.
REQ-034 Scenario: requester 1 issues 50-100 (op 100010). Response: o_rsp_result=206 (0xCE), o_rsp_zero=0, overflow passes through from the ALU. Follow-up: 0+0 gives result 0, o_rsp_zero=1.
REQ-035 Scenario: i_rst=0 during LOAD_B. Response: next cycle all outputs 0, o_busy 0, no o_rsp_valid. A subsequent lone request from requester 1 is granted normally.
REQ-036 Scenario: i_a0 changed from 10 to 99 in cycle N+1 after grant. Response: o_data=10 in LOAD_A.
